// File: rtl/wbs_slave_bridge.sv
// Wishbone slave terminating the user-project bus: control/status registers plus
// query/leaf/node write windows and a registered best-index read path.
module wbs_slave_bridge #(
    parameter int DATA_WIDTH       = 11,
    parameter int QUERY_ADDR_WIDTH = 9,
    parameter int LEAF_ADDR_WIDTH  = 9,
    parameter int NODE_ADDR_WIDTH  = 6,
    parameter int BEST_ADDR_WIDTH  = 9
) (
    input  logic                        wb_clk_i,
    input  logic                        rst_n,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_we_i,
    input  logic [3:0]                  wbs_sel_i,
    input  logic [31:0]                 wbs_adr_i,
    input  logic [31:0]                 wbs_dat_i,
    output logic                        wbs_ack_o,
    output logic [31:0]                 wbs_dat_o,
    output logic                        mode_o,
    output logic                        debug_o,
    output logic                        fsm_start_o,
    input  logic                        fsm_done_i,
    input  logic                        fsm_busy_i,
    output logic                        query_wen_o,
    output logic [QUERY_ADDR_WIDTH-1:0] query_addr_o,
    output logic [5*DATA_WIDTH-1:0]     query_wdata_o,
    output logic                        leaf_wen_o,
    output logic [LEAF_ADDR_WIDTH-1:0]  leaf_addr_o,
    output logic [63:0]                 leaf_wdata_o,
    output logic                        node_wen_o,
    output logic [NODE_ADDR_WIDTH-1:0]  node_addr_o,
    output logic [2*DATA_WIDTH-1:0]     node_wdata_o,
    output logic                        best_ren_o,
    output logic [BEST_ADDR_WIDTH-1:0]  best_addr_o,
    input  logic [DATA_WIDTH-1:0]       best_rdata_i
);

    localparam logic [31:0] ADR_MODE   = 32'h3000_0000;
    localparam logic [31:0] ADR_DEBUG  = 32'h3000_0004;
    localparam logic [31:0] ADR_DONE   = 32'h3000_0008;
    localparam logic [31:0] ADR_START  = 32'h3000_000C;
    localparam logic [31:0] ADR_BUSY   = 32'h3000_0010;
    localparam logic [31:0] BASE_QUERY = 32'h3001_0000;
    localparam logic [31:0] BASE_LEAF  = 32'h3002_0000;
    localparam logic [31:0] BASE_BEST  = 32'h3003_0000;
    localparam logic [31:0] BASE_NODE  = 32'h3004_0000;
    localparam int          QW         = 5 * DATA_WIDTH;
    localparam int          NW         = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_RDWAIT, ST_ACK, ST_RECOVER} state_e;

    state_e                      state_q, state_d;
    logic                        ack_q, ack_d;
    logic [31:0]                 dat_q, dat_d;
    logic                        mode_q, mode_d;
    logic                        debug_q, debug_d;
    logic                        done_q, done_d;
    logic                        start_q, start_d;
    logic [31:0]                 hold_q, hold_d;
    logic                        query_wen_q, query_wen_d;
    logic [QUERY_ADDR_WIDTH-1:0] query_addr_q, query_addr_d;
    logic [QW-1:0]               query_wdata_q, query_wdata_d;
    logic                        leaf_wen_q, leaf_wen_d;
    logic [LEAF_ADDR_WIDTH-1:0]  leaf_addr_q, leaf_addr_d;
    logic [63:0]                 leaf_wdata_q, leaf_wdata_d;
    logic                        node_wen_q, node_wen_d;
    logic [NODE_ADDR_WIDTH-1:0]  node_addr_q, node_addr_d;
    logic [NW-1:0]               node_wdata_q, node_wdata_d;
    logic                        best_ren_q, best_ren_d;
    logic [BEST_ADDR_WIDTH-1:0]  best_addr_q, best_addr_d;

    logic        req;
    logic [31:0] win;
    logic        hit_mode, hit_debug, hit_done, hit_start, hit_busy;
    logic        hit_query, hit_leaf, hit_best, hit_node;
    logic        best_rd_lo;
    logic [63:0] wide_wdata;
    logic        unused_sel;

    assign unused_sel = ^wbs_sel_i;

    assign req        = wbs_cyc_i & wbs_stb_i;
    assign win        = wbs_adr_i & 32'hFFFF_0000;
    assign hit_mode   = (wbs_adr_i == ADR_MODE);
    assign hit_debug  = (wbs_adr_i == ADR_DEBUG);
    assign hit_done   = (wbs_adr_i == ADR_DONE);
    assign hit_start  = (wbs_adr_i == ADR_START);
    assign hit_busy   = (wbs_adr_i == ADR_BUSY);
    assign hit_query  = (win == BASE_QUERY);
    assign hit_leaf   = (win == BASE_LEAF);
    assign hit_best   = (win == BASE_BEST);
    assign hit_node   = (win == BASE_NODE);
    assign best_rd_lo = hit_best & ~wbs_we_i & ~wbs_adr_i[2];
    // Upper half of a query/leaf pair carries the high word; the hold register the low one.
    assign wide_wdata = {wbs_dat_i, hold_q};

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req) state_d = best_rd_lo ? ST_RDWAIT : ST_ACK;
            ST_RDWAIT:  state_d = ST_ACK;
            ST_ACK:     state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Strobes, addresses and read data default to zero so they only live for one cycle.
    always_comb begin
        ack_d         = 1'b0;
        dat_d         = '0;
        mode_d        = mode_q;
        debug_d       = debug_q;
        done_d        = done_q | fsm_done_i;
        start_d       = 1'b0;
        hold_d        = hold_q;
        query_wen_d   = 1'b0;
        query_addr_d  = '0;
        query_wdata_d = '0;
        leaf_wen_d    = 1'b0;
        leaf_addr_d   = '0;
        leaf_wdata_d  = '0;
        node_wen_d    = 1'b0;
        node_addr_d   = '0;
        node_wdata_d  = '0;
        best_ren_d    = 1'b0;
        best_addr_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    ack_d = ~best_rd_lo;
                    if (wbs_we_i) begin
                        if (hit_mode)  mode_d  = wbs_dat_i[0];
                        if (hit_debug) debug_d = wbs_dat_i[0];
                        if (hit_done)  done_d  = fsm_done_i;
                        if (hit_start) start_d = 1'b1;
                        if (hit_query) begin
                            if (!wbs_adr_i[2]) begin
                                hold_d = wbs_dat_i;
                            end else begin
                                query_wen_d   = 1'b1;
                                query_addr_d  = wbs_adr_i[3 +: QUERY_ADDR_WIDTH];
                                query_wdata_d = wide_wdata[QW-1:0];
                            end
                        end
                        if (hit_leaf) begin
                            if (!wbs_adr_i[2]) begin
                                hold_d = wbs_dat_i;
                            end else begin
                                leaf_wen_d   = 1'b1;
                                leaf_addr_d  = wbs_adr_i[3 +: LEAF_ADDR_WIDTH];
                                leaf_wdata_d = wide_wdata;
                            end
                        end
                        if (hit_node) begin
                            node_wen_d   = 1'b1;
                            node_addr_d  = wbs_adr_i[2 +: NODE_ADDR_WIDTH];
                            node_wdata_d = wbs_dat_i[NW-1:0];
                        end
                    end else begin
                        if (hit_mode)  dat_d = {31'b0, mode_q};
                        if (hit_debug) dat_d = {31'b0, debug_q};
                        if (hit_done)  dat_d = {31'b0, done_q};
                        if (hit_busy)  dat_d = {31'b0, fsm_busy_i};
                        if (best_rd_lo) begin
                            best_ren_d  = 1'b1;
                            best_addr_d = wbs_adr_i[3 +: BEST_ADDR_WIDTH];
                        end
                    end
                end
            end
            ST_RDWAIT: begin
                ack_d = 1'b1;
                dat_d = {{(32-DATA_WIDTH){1'b0}}, best_rdata_i};
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_q         <= 1'b0;
            dat_q         <= '0;
            mode_q        <= 1'b0;
            debug_q       <= 1'b0;
            done_q        <= 1'b0;
            start_q       <= 1'b0;
            hold_q        <= '0;
            query_wen_q   <= 1'b0;
            query_addr_q  <= '0;
            query_wdata_q <= '0;
            leaf_wen_q    <= 1'b0;
            leaf_addr_q   <= '0;
            leaf_wdata_q  <= '0;
            node_wen_q    <= 1'b0;
            node_addr_q   <= '0;
            node_wdata_q  <= '0;
            best_ren_q    <= 1'b0;
            best_addr_q   <= '0;
        end else begin
            ack_q         <= ack_d;
            dat_q         <= dat_d;
            mode_q        <= mode_d;
            debug_q       <= debug_d;
            done_q        <= done_d;
            start_q       <= start_d;
            hold_q        <= hold_d;
            query_wen_q   <= query_wen_d;
            query_addr_q  <= query_addr_d;
            query_wdata_q <= query_wdata_d;
            leaf_wen_q    <= leaf_wen_d;
            leaf_addr_q   <= leaf_addr_d;
            leaf_wdata_q  <= leaf_wdata_d;
            node_wen_q    <= node_wen_d;
            node_addr_q   <= node_addr_d;
            node_wdata_q  <= node_wdata_d;
            best_ren_q    <= best_ren_d;
            best_addr_q   <= best_addr_d;
        end
    end

    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = dat_q;
    assign mode_o        = mode_q;
    assign debug_o       = debug_q;
    assign fsm_start_o   = start_q;
    assign query_wen_o   = query_wen_q;
    assign query_addr_o  = query_addr_q;
    assign query_wdata_o = query_wdata_q;
    assign leaf_wen_o    = leaf_wen_q;
    assign leaf_addr_o   = leaf_addr_q;
    assign leaf_wdata_o  = leaf_wdata_q;
    assign node_wen_o    = node_wen_q;
    assign node_addr_o   = node_addr_q;
    assign node_wdata_o  = node_wdata_q;
    assign best_ren_o    = best_ren_q;
    assign best_addr_o   = best_addr_q;

endmodule

// File: tb/tb_wbs_slave_bridge.sv
// Directed bench for wbs_slave_bridge: a vector table of single transactions
// plus hand-written sequences for reset abort, held strobe and DONE behaviour.
module tb_wbs_slave_bridge;

    logic        clk;
    logic        rst_n;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        mode_o, debug_o, fsm_start_o;
    logic        fsm_done_i, fsm_busy_i;
    logic        query_wen_o;
    logic [8:0]  query_addr_o;
    logic [54:0] query_wdata_o;
    logic        leaf_wen_o;
    logic [8:0]  leaf_addr_o;
    logic [63:0] leaf_wdata_o;
    logic        node_wen_o;
    logic [5:0]  node_addr_o;
    logic [21:0] node_wdata_o;
    logic        best_ren_o;
    logic [8:0]  best_addr_o;
    logic [10:0] best_rdata_i;

    wbs_slave_bridge dut (
        .wb_clk_i      (clk),
        .rst_n         (rst_n),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .mode_o        (mode_o),
        .debug_o       (debug_o),
        .fsm_start_o   (fsm_start_o),
        .fsm_done_i    (fsm_done_i),
        .fsm_busy_i    (fsm_busy_i),
        .query_wen_o   (query_wen_o),
        .query_addr_o  (query_addr_o),
        .query_wdata_o (query_wdata_o),
        .leaf_wen_o    (leaf_wen_o),
        .leaf_addr_o   (leaf_addr_o),
        .leaf_wdata_o  (leaf_wdata_o),
        .node_wen_o    (node_wen_o),
        .node_addr_o   (node_addr_o),
        .node_wdata_o  (node_wdata_o),
        .best_ren_o    (best_ren_o),
        .best_addr_o   (best_addr_o),
        .best_rdata_i  (best_rdata_i)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [10:0] brd;
        logic        busy;
        int          lat;
        logic [31:0] rdata;
        logic        qwen;
        logic        lwen;
        logic        nwen;
        logic        start;
        logic [63:0] expAddr;
        logic [63:0] expWdata;
        logic        mode;
        logic        debug;
    } vec_t;

    typedef struct {
        logic        ack;
        logic [31:0] dat;
        logic        qwen, lwen, nwen, start, ren;
        logic [8:0]  qaddr, laddr, baddr;
        logic [5:0]  naddr;
        logic [54:0] qwd;
        logic [63:0] lwd;
        logic [21:0] nwd;
        logic        mode, debug;
    } snap_t;

    int    checks = 0;
    int    errors = 0;
    vec_t  vecs[$];
    snap_t c1, c2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    function automatic snap_t takeSnap();
        snap_t s;
        s.ack   = wbs_ack_o;
        s.dat   = wbs_dat_o;
        s.qwen  = query_wen_o;
        s.lwen  = leaf_wen_o;
        s.nwen  = node_wen_o;
        s.start = fsm_start_o;
        s.ren   = best_ren_o;
        s.qaddr = query_addr_o;
        s.laddr = leaf_addr_o;
        s.baddr = best_addr_o;
        s.naddr = node_addr_o;
        s.qwd   = query_wdata_o;
        s.lwd   = leaf_wdata_o;
        s.nwd   = node_wdata_o;
        s.mode  = mode_o;
        s.debug = debug_o;
        return s;
    endfunction

    // One transaction sampled at edge N; c1 holds cycle N+1, c2 cycle N+2.
    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                                 input logic [10:0] brd, input logic busy, input logic pulseDone);
        @(negedge clk);
        wbs_cyc_i    = 1'b1;
        wbs_stb_i    = 1'b1;
        wbs_we_i     = we;
        wbs_adr_i    = adr;
        wbs_dat_i    = wdat;
        best_rdata_i = brd;
        fsm_busy_i   = busy;
        fsm_done_i   = pulseDone;
        @(posedge clk);
        #1;
        wbs_cyc_i  = 1'b0;
        wbs_stb_i  = 1'b0;
        wbs_we_i   = 1'b0;
        fsm_done_i = 1'b0;
        c1 = takeSnap();
        @(posedge clk);
        #1;
        c2 = takeSnap();
        repeat (2) @(posedge clk);
    endtask

    function automatic void addVec(input string name, input logic we, input logic [31:0] adr,
                                   input logic [31:0] wdat, input logic [10:0] brd, input logic busy,
                                   input int lat, input logic [31:0] rdata, input logic qwen,
                                   input logic lwen, input logic nwen, input logic start,
                                   input logic [63:0] expAddr, input logic [63:0] expWdata,
                                   input logic mode, input logic debug);
        vec_t v;
        v.name = name;  v.we = we;   v.adr = adr;     v.wdat = wdat;
        v.brd = brd;    v.busy = busy; v.lat = lat;   v.rdata = rdata;
        v.qwen = qwen;  v.lwen = lwen; v.nwen = nwen; v.start = start;
        v.expAddr = expAddr; v.expWdata = expWdata; v.mode = mode; v.debug = debug;
        vecs.push_back(v);
    endfunction

    vec_t  v;
    snap_t ackSnap, otherSnap;
    int    ackCycles[$];
    int    nodePulses;

    initial begin
        rst_n        = 1'b0;
        wbs_cyc_i    = 1'b0;
        wbs_stb_i    = 1'b0;
        wbs_we_i     = 1'b0;
        wbs_sel_i    = 4'hF;
        wbs_adr_i    = '0;
        wbs_dat_i    = '0;
        fsm_done_i   = 1'b0;
        fsm_busy_i   = 1'b0;
        best_rdata_i = '0;

        //     name            we  adr            wdat           brd     busy lat rdata  q  l  n  st expAddr  expWdata                 mode dbg
        addVec("wr_debug",     1, 32'h3000_0004, 32'h0000_0001, 11'h0,   0,  1, 32'h0, 0, 0, 0, 0, 64'h0,   64'h0,                   0,   1);
        addVec("rd_debug",     0, 32'h3000_0004, 32'h0,         11'h0,   0,  1, 32'h1, 0, 0, 0, 0, 64'h0,   64'h0,                   0,   1);
        addVec("wr_mode",      1, 32'h3000_0000, 32'h0000_0003, 11'h0,   0,  1, 32'h0, 0, 0, 0, 0, 64'h0,   64'h0,                   1,   1);
        addVec("rd_mode",      0, 32'h3000_0000, 32'h0,         11'h0,   0,  1, 32'h1, 0, 0, 0, 0, 64'h0,   64'h0,                   1,   1);
        addVec("leaf_lo",      1, 32'h3002_0008, 32'hDEAD_BEEF, 11'h0,   0,  1, 32'h0, 0, 0, 0, 0, 64'h0,   64'h0,                   1,   1);
        addVec("leaf_hi",      1, 32'h3002_000C, 32'h1234_5678, 11'h0,   0,  1, 32'h0, 0, 1, 0, 0, 64'h1,   64'h1234_5678_DEAD_BEEF, 1,   1);
        addVec("query_lo",     1, 32'h3001_0010, 32'hCAFE_F00D, 11'h0,   0,  1, 32'h0, 0, 0, 0, 0, 64'h0,   64'h0,                   1,   1);
        addVec("query_hi",     1, 32'h3001_0014, 32'hFFFF_FFFF, 11'h0,   0,  1, 32'h0, 1, 0, 0, 0, 64'h2,   64'h007F_FFFF_CAFE_F00D, 1,   1);
        addVec("node_a",       1, 32'h3004_0004, 32'h0037_0001, 11'h0,   0,  1, 32'h0, 0, 0, 1, 0, 64'h1,   64'h37_0001,             1,   1);
        addVec("node_b",       1, 32'h3004_00FC, 32'hFFFF_FFFF, 11'h0,   0,  1, 32'h0, 0, 0, 1, 0, 64'h3F,  64'h3F_FFFF,             1,   1);
        addVec("best_rd5",     0, 32'h3003_0028, 32'h0,         11'h123, 0,  2, 32'h123, 0, 0, 0, 0, 64'h5, 64'h0,                   1,   1);
        addVec("best_hi",      0, 32'h3003_002C, 32'h0,         11'h123, 0,  1, 32'h0, 0, 0, 0, 0, 64'h0,   64'h0,                   1,   1);
        addVec("rd_busy1",     0, 32'h3000_0010, 32'h0,         11'h0,   1,  1, 32'h1, 0, 0, 0, 0, 64'h0,   64'h0,                   1,   1);
        addVec("rd_busy0",     0, 32'h3000_0010, 32'h0,         11'h0,   0,  1, 32'h0, 0, 0, 0, 0, 64'h0,   64'h0,                   1,   1);
        addVec("rd_start",     0, 32'h3000_000C, 32'h0,         11'h0,   1,  1, 32'h0, 0, 0, 0, 0, 64'h0,   64'h0,                   1,   1);
        addVec("wr_unmapped",  1, 32'h3005_0000, 32'h0000_0001, 11'h0,   0,  1, 32'h0, 0, 0, 0, 0, 64'h0,   64'h0,                   1,   1);
        addVec("rd_leafwin",   0, 32'h3002_0008, 32'h0,         11'h7FF, 0,  1, 32'h0, 0, 0, 0, 0, 64'h0,   64'h0,                   1,   1);
        addVec("wr_best",      1, 32'h3003_0000, 32'h0000_FFFF, 11'h0,   0,  1, 32'h0, 0, 0, 0, 0, 64'h0,   64'h0,                   1,   1);
        addVec("rd_done0",     0, 32'h3000_0008, 32'h0,         11'h0,   0,  1, 32'h0, 0, 0, 0, 0, 64'h0,   64'h0,                   1,   1);
        addVec("leaf_hi_nolo", 1, 32'h3002_0024, 32'h0000_0001, 11'h0,   0,  1, 32'h0, 0, 1, 0, 0, 64'h4,   64'h0000_0001_CAFE_F00D, 1,   1);
        addVec("best_rd511",   0, 32'h3003_0FF8, 32'h0,         11'h7FF, 0,  2, 32'h7FF, 0, 0, 0, 0, 64'h1FF, 64'h0,                 1,   1);
        addVec("wr_start",     1, 32'h3000_000C, 32'h0,         11'h0,   0,  1, 32'h0, 0, 0, 0, 1, 64'h0,   64'h0,                   1,   1);
        addVec("rd_reg_alias", 0, 32'h3000_0001, 32'h0,         11'h0,   1,  1, 32'h0, 0, 0, 0, 0, 64'h0,   64'h0,                   1,   1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ack",   64'(wbs_ack_o), 64'h0);
        checkOutput("reset_dat",   64'(wbs_dat_o), 64'h0);
        checkOutput("reset_mode",  64'(mode_o), 64'h0);
        checkOutput("reset_debug", 64'(debug_o), 64'h0);
        checkOutput("reset_strobes",
                    64'({fsm_start_o, query_wen_o, leaf_wen_o, node_wen_o, best_ren_o}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v.we, v.adr, v.wdat, v.brd, v.busy, 1'b0);
            if (v.lat == 2) begin
                ackSnap   = c2;
                otherSnap = c1;
            end else begin
                ackSnap   = c1;
                otherSnap = c2;
            end
            checkOutput({v.name, " ack_n1"}, 64'(c1.ack), 64'(v.lat == 1));
            checkOutput({v.name, " ack_n2"}, 64'(c2.ack), 64'(v.lat == 2));
            checkOutput({v.name, " rdata"}, 64'(ackSnap.dat), 64'(v.rdata));
            checkOutput({v.name, " strobes"},
                        64'({ackSnap.qwen, ackSnap.lwen, ackSnap.nwen, ackSnap.start}),
                        64'({v.qwen, v.lwen, v.nwen, v.start}));
            checkOutput({v.name, " strobes_off"},
                        64'({otherSnap.qwen, otherSnap.lwen, otherSnap.nwen, otherSnap.start}), 64'h0);
            checkOutput({v.name, " ren"}, 64'(c1.ren), 64'(v.lat == 2));
            checkOutput({v.name, " mode"}, 64'(ackSnap.mode), 64'(v.mode));
            checkOutput({v.name, " debug"}, 64'(ackSnap.debug), 64'(v.debug));
            if (v.qwen) begin
                checkOutput({v.name, " qaddr"}, 64'(ackSnap.qaddr), v.expAddr);
                checkOutput({v.name, " qwdata"}, 64'(ackSnap.qwd), v.expWdata);
            end
            if (v.lwen) begin
                checkOutput({v.name, " laddr"}, 64'(ackSnap.laddr), v.expAddr);
                checkOutput({v.name, " lwdata"}, 64'(ackSnap.lwd), v.expWdata);
            end
            if (v.nwen) begin
                checkOutput({v.name, " naddr"}, 64'(ackSnap.naddr), v.expAddr);
                checkOutput({v.name, " nwdata"}, 64'(ackSnap.nwd), v.expWdata);
            end
            if (v.lat == 2) begin
                checkOutput({v.name, " baddr"}, 64'(c1.baddr), v.expAddr);
            end
        end

        // Reset asserted while a start write is being acknowledged.
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = 32'h3000_000C;
        wbs_dat_i = 32'h0;
        @(posedge clk);
        #1;
        checkOutput("abort_pre_ack",   64'(wbs_ack_o), 64'h1);
        checkOutput("abort_pre_start", 64'(fsm_start_o), 64'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ack",   64'(wbs_ack_o), 64'h0);
        checkOutput("abort_start", 64'(fsm_start_o), 64'h0);
        checkOutput("abort_mode",  64'(mode_o), 64'h0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h3000_0000, 32'h0, 11'h0, 1'b0, 1'b0);
        checkOutput("post_reset_mode_rd", 64'({c1.ack, c1.dat}), 64'h1_0000_0000);
        applyStimulus(1'b1, 32'h3002_000C, 32'h0000_000A, 11'h0, 1'b0, 1'b0);
        checkOutput("post_reset_hold_wen",   64'(c1.lwen), 64'h1);
        checkOutput("post_reset_hold_wdata", c1.lwd, 64'h0000_000A_0000_0000);

        // Strobe held high on a node write: one transaction per three cycles.
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = 32'h3004_0004;
        wbs_dat_i = 32'h0037_0001;
        nodePulses = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk);
            #1;
            if (wbs_ack_o) ackCycles.push_back(cyc);
            if (node_wen_o) nodePulses++;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (ackCycles.size() < 2) begin
            checkOutput("held_stb_ack_count", 64'(ackCycles.size()), 64'h3);
        end else begin
            checkOutput("held_stb_first_ack", 64'(ackCycles[0]), 64'h1);
            checkOutput("held_stb_spacing", 64'(ackCycles[1] - ackCycles[0]), 64'h3);
            checkOutput("held_stb_ack_count", 64'(ackCycles.size()), 64'h3);
        end
        checkOutput("held_stb_node_pulses", 64'(nodePulses), 64'h3);
        repeat (3) @(posedge clk);

        // DONE is sticky, cleared by a write, and a coincident set wins.
        @(negedge clk);
        fsm_done_i = 1'b1;
        @(negedge clk);
        fsm_done_i = 1'b0;
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 11'h0, 1'b0, 1'b0);
        checkOutput("done_set_rd", 64'(c1.dat), 64'h1);
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 11'h0, 1'b0, 1'b0);
        checkOutput("done_sticky_rd", 64'(c1.dat), 64'h1);
        applyStimulus(1'b1, 32'h3000_0008, 32'h0, 11'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 11'h0, 1'b0, 1'b0);
        checkOutput("done_set_wins_rd", 64'(c1.dat), 64'h1);
        applyStimulus(1'b1, 32'h3000_0008, 32'h0, 11'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 11'h0, 1'b0, 1'b0);
        checkOutput("done_cleared_rd", 64'(c1.dat), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
